// File: rtl/simplerisc_pkg.sv
// SimpleRisc shared definitions: opcodes, control-bus bit positions, NOP encoding.
package simplerisc_pkg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 22;
  localparam int ALU_W  = 13;

  // Opcodes (IR[31:27])
  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_MUL  = 5'd2;
  localparam logic [4:0] OP_DIV  = 5'd3;
  localparam logic [4:0] OP_MOD  = 5'd4;
  localparam logic [4:0] OP_CMP  = 5'd5;
  localparam logic [4:0] OP_AND  = 5'd6;
  localparam logic [4:0] OP_OR   = 5'd7;
  localparam logic [4:0] OP_NOT  = 5'd8;
  localparam logic [4:0] OP_MOV  = 5'd9;
  localparam logic [4:0] OP_LSL  = 5'd10;
  localparam logic [4:0] OP_LSR  = 5'd11;
  localparam logic [4:0] OP_ASR  = 5'd12;
  localparam logic [4:0] OP_NOP  = 5'd13;
  localparam logic [4:0] OP_LD   = 5'd14;
  localparam logic [4:0] OP_ST   = 5'd15;
  localparam logic [4:0] OP_BEQ  = 5'd16;
  localparam logic [4:0] OP_BGT  = 5'd17;
  localparam logic [4:0] OP_B    = 5'd18;
  localparam logic [4:0] OP_CALL = 5'd19;
  localparam logic [4:0] OP_RET  = 5'd20;

  // Control-bus bit positions: instruction-class flags in the upper field
  localparam int C_IS_ST      = 21;
  localparam int C_IS_LD      = 20;
  localparam int C_IS_BEQ     = 19;
  localparam int C_IS_BGT     = 18;
  localparam int C_IS_RET     = 17;
  localparam int C_IS_IMM     = 16;
  localparam int C_IS_WB      = 15;
  localparam int C_IS_UBRANCH = 14;
  localparam int C_IS_CALL    = 13;
  // ALU one-hot selects occupy bits 12..0 so the low slice feeds the ALU directly
  localparam int C_ADD = 12;
  localparam int C_SUB = 11;
  localparam int C_CMP = 10;
  localparam int C_MUL = 9;
  localparam int C_DIV = 8;
  localparam int C_MOD = 7;
  localparam int C_LSL = 6;
  localparam int C_LSR = 5;
  localparam int C_ASR = 4;
  localparam int C_OR  = 3;
  localparam int C_AND = 2;
  localparam int C_NOT = 1;
  localparam int C_MOV = 0;

  localparam logic [XLEN-1:0] NOP_IR = 32'h6800_0000;

endpackage

// File: rtl/ex_alu.sv
// Combinational SimpleRisc ALU driven by the one-hot ALU slice of the control bus.
module ex_alu
  import simplerisc_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [ALU_W-1:0] alu_sel,
  output logic [W-1:0]     result
);

  logic [W-1:0] quot;
  logic [W-1:0] rem;

  // Signed divide/remainder; zero divisor yields 0, most-negative / -1 wraps
  always_comb begin
    quot = '0;
    rem  = '0;
    if (b == '0) begin
      quot = '0;
      rem  = '0;
    end else if ((a == {1'b1, {(W-1){1'b0}}}) && (b == {W{1'b1}})) begin
      quot = a;
      rem  = '0;
    end else begin
      quot = $signed(a) / $signed(b);
      rem  = $signed(a) % $signed(b);
    end
  end

  // Result select; cmp and no-select produce 0
  always_comb begin
    result = '0;
    if (alu_sel[C_ADD])      result = a + b;
    else if (alu_sel[C_SUB]) result = a - b;
    else if (alu_sel[C_MUL]) result = a * b;
    else if (alu_sel[C_DIV]) result = quot;
    else if (alu_sel[C_MOD]) result = rem;
    else if (alu_sel[C_LSL]) result = a << b[4:0];
    else if (alu_sel[C_LSR]) result = a >> b[4:0];
    else if (alu_sel[C_ASR]) result = $signed(a) >>> b[4:0];
    else if (alu_sel[C_OR])  result = a | b;
    else if (alu_sel[C_AND]) result = a & b;
    else if (alu_sel[C_NOT]) result = ~b;
    else if (alu_sel[C_MOV]) result = b;
  end

endmodule

// File: rtl/ex_stage_pipe.sv
// SimpleRisc execute slice: OF decoder, forwarding, ALU, flags, branch resolve, EX/MA latch.
module ex_stage_pipe
  import simplerisc_pkg::*;
#(
  parameter int W  = 32,
  parameter int CW = 22
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  of_ir,
  output logic [CW-1:0] of_ctrl,
  input  logic [W-1:0]  ex_pc,
  input  logic [W-1:0]  ex_branch_target,
  input  logic [W-1:0]  ex_op_a,
  input  logic [W-1:0]  ex_op_b,
  input  logic [W-1:0]  ex_op2,
  input  logic [W-1:0]  ex_ir,
  input  logic [CW-1:0] ex_ctrl,
  input  logic [W-1:0]  fwd_rw_data,
  input  logic [W-1:0]  fwd_ma_alu,
  input  logic          rw_ex_src1,
  input  logic          rw_ex_src2,
  input  logic          ma_ex_src1,
  input  logic          ma_ex_src2,
  output logic          branch_taken,
  output logic [W-1:0]  branch_pc,
  output logic [W-1:0]  ma_pc,
  output logic [W-1:0]  ma_alu_result,
  output logic [W-1:0]  ma_op2,
  output logic [W-1:0]  ma_ir,
  output logic [CW-1:0] ma_ctrl
);

  logic [4:0]   of_opcode;
  logic         of_imm_bit;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] src2_fwd;
  logic [W-1:0] op2_fwd;
  logic [W-1:0] alu_result;

  logic          flag_e_d,  flag_e_q;
  logic          flag_gt_d, flag_gt_q;
  logic [W-1:0]  ma_pc_d,   ma_pc_q;
  logic [W-1:0]  ma_alu_d,  ma_alu_q;
  logic [W-1:0]  ma_op2_d,  ma_op2_q;
  logic [W-1:0]  ma_ir_d,   ma_ir_q;
  logic [CW-1:0] ma_ctrl_d, ma_ctrl_q;

  // Fields the decoder does not look at, and control bits consumed later in the pipe
  logic unused_fields;
  assign unused_fields = ^{of_ir[25:0], ex_ctrl[C_IS_ST], ex_ctrl[C_IS_LD],
                           ex_ctrl[C_IS_WB], ex_ctrl[C_IS_CALL]};

  assign of_opcode  = of_ir[31:27];
  assign of_imm_bit = of_ir[26];

  // Control decoder for the instruction in OF; held at zero during reset
  always_comb begin
    of_ctrl = '0;
    if (reset) begin
      case (of_opcode)
        OP_ADD:  of_ctrl[C_ADD] = 1'b1;
        OP_SUB:  of_ctrl[C_SUB] = 1'b1;
        OP_MUL:  of_ctrl[C_MUL] = 1'b1;
        OP_DIV:  of_ctrl[C_DIV] = 1'b1;
        OP_MOD:  of_ctrl[C_MOD] = 1'b1;
        OP_CMP:  of_ctrl[C_CMP] = 1'b1;
        OP_AND:  of_ctrl[C_AND] = 1'b1;
        OP_OR:   of_ctrl[C_OR]  = 1'b1;
        OP_NOT:  of_ctrl[C_NOT] = 1'b1;
        OP_MOV:  of_ctrl[C_MOV] = 1'b1;
        OP_LSL:  of_ctrl[C_LSL] = 1'b1;
        OP_LSR:  of_ctrl[C_LSR] = 1'b1;
        OP_ASR:  of_ctrl[C_ASR] = 1'b1;
        OP_LD: begin
          of_ctrl[C_IS_LD]  = 1'b1;
          of_ctrl[C_ADD]    = 1'b1;
          of_ctrl[C_IS_IMM] = 1'b1;
          of_ctrl[C_IS_WB]  = 1'b1;
        end
        OP_ST: begin
          of_ctrl[C_IS_ST]  = 1'b1;
          of_ctrl[C_ADD]    = 1'b1;
          of_ctrl[C_IS_IMM] = 1'b1;
        end
        OP_BEQ:  of_ctrl[C_IS_BEQ] = 1'b1;
        OP_BGT:  of_ctrl[C_IS_BGT] = 1'b1;
        OP_B:    of_ctrl[C_IS_UBRANCH] = 1'b1;
        OP_CALL: begin
          of_ctrl[C_IS_UBRANCH] = 1'b1;
          of_ctrl[C_IS_CALL]    = 1'b1;
          of_ctrl[C_IS_WB]      = 1'b1;
        end
        OP_RET: begin
          of_ctrl[C_IS_UBRANCH] = 1'b1;
          of_ctrl[C_IS_RET]     = 1'b1;
        end
        default: of_ctrl = '0;
      endcase
      // ALU-format instructions take I from the IR; all but cmp write back
      if (of_opcode <= OP_ASR) begin
        of_ctrl[C_IS_IMM] = of_imm_bit;
        if (of_opcode != OP_CMP) of_ctrl[C_IS_WB] = 1'b1;
      end
    end
  end

  // Operand forwarding: the younger MA result wins over the RW value
  always_comb begin
    op_a = ex_op_a;
    if (ma_ex_src1)      op_a = fwd_ma_alu;
    else if (rw_ex_src1) op_a = fwd_rw_data;

    src2_fwd = ex_op_b;
    if (ma_ex_src2)      src2_fwd = fwd_ma_alu;
    else if (rw_ex_src2) src2_fwd = fwd_rw_data;

    op2_fwd = ex_op2;
    if (ma_ex_src2)      op2_fwd = fwd_ma_alu;
    else if (rw_ex_src2) op2_fwd = fwd_rw_data;

    op_b = ex_ctrl[C_IS_IMM] ? ex_op_b : src2_fwd;
  end

  ex_alu #(.W(W)) u_alu (
    .a       (op_a),
    .b       (op_b),
    .alu_sel (ex_ctrl[ALU_W-1:0]),
    .result  (alu_result)
  );

  // Flags capture the comparison of the forwarded operands on cmp, else hold
  always_comb begin
    flag_e_d  = flag_e_q;
    flag_gt_d = flag_gt_q;
    if (ex_ctrl[C_CMP]) begin
      flag_e_d  = (op_a == op_b);
      flag_gt_d = ($signed(op_a) > $signed(op_b));
    end
  end

  // Branch resolution from registered flags; silent during reset
  always_comb begin
    branch_taken = 1'b0;
    branch_pc    = '0;
    if (reset) begin
      branch_taken = ex_ctrl[C_IS_UBRANCH]
                   | (ex_ctrl[C_IS_BEQ] & flag_e_q)
                   | (ex_ctrl[C_IS_BGT] & flag_gt_q);
      branch_pc    = ex_ctrl[C_IS_RET] ? op_a : ex_branch_target;
    end
  end

  // EX/MA latch next-state: loads every cycle, bubbles arrive as nop
  always_comb begin
    ma_pc_d   = ex_pc;
    ma_alu_d  = alu_result;
    ma_op2_d  = op2_fwd;
    ma_ir_d   = ex_ir;
    ma_ctrl_d = ex_ctrl;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      flag_e_q  <= 1'b0;
      flag_gt_q <= 1'b0;
      ma_pc_q   <= '0;
      ma_alu_q  <= '0;
      ma_op2_q  <= '0;
      ma_ir_q   <= NOP_IR;
      ma_ctrl_q <= '0;
    end else begin
      flag_e_q  <= flag_e_d;
      flag_gt_q <= flag_gt_d;
      ma_pc_q   <= ma_pc_d;
      ma_alu_q  <= ma_alu_d;
      ma_op2_q  <= ma_op2_d;
      ma_ir_q   <= ma_ir_d;
      ma_ctrl_q <= ma_ctrl_d;
    end
  end

  assign ma_pc         = ma_pc_q;
  assign ma_alu_result = ma_alu_q;
  assign ma_op2        = ma_op2_q;
  assign ma_ir         = ma_ir_q;
  assign ma_ctrl       = ma_ctrl_q;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Bench for ex_stage_pipe: directed steps plus randomized instructions against a reference model.
module tb_ex_stage_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] of_ir;
  logic [21:0] of_ctrl;
  logic [31:0] ex_pc, ex_branch_target, ex_op_a, ex_op_b, ex_op2, ex_ir;
  logic [21:0] ex_ctrl;
  logic [31:0] fwd_rw_data, fwd_ma_alu;
  logic        rw_ex_src1, rw_ex_src2, ma_ex_src1, ma_ex_src2;
  logic        branch_taken;
  logic [31:0] branch_pc;
  logic [31:0] ma_pc, ma_alu_result, ma_op2, ma_ir;
  logic [21:0] ma_ctrl;

  int checks = 0;
  int errors = 0;

  // reference flag state
  logic e_m  = 1'b0;
  logic gt_m = 1'b0;

  // clock
  always #5 clk = ~clk;

  ex_stage_pipe dut (
    .clk(clk), .reset(reset),
    .of_ir(of_ir), .of_ctrl(of_ctrl),
    .ex_pc(ex_pc), .ex_branch_target(ex_branch_target),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_op2(ex_op2),
    .ex_ir(ex_ir), .ex_ctrl(ex_ctrl),
    .fwd_rw_data(fwd_rw_data), .fwd_ma_alu(fwd_ma_alu),
    .rw_ex_src1(rw_ex_src1), .rw_ex_src2(rw_ex_src2),
    .ma_ex_src1(ma_ex_src1), .ma_ex_src2(ma_ex_src2),
    .branch_taken(branch_taken), .branch_pc(branch_pc),
    .ma_pc(ma_pc), .ma_alu_result(ma_alu_result), .ma_op2(ma_op2),
    .ma_ir(ma_ir), .ma_ctrl(ma_ctrl)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_ir(input int op, input bit i, input int rd, input int rs1, input int rs2);
    logic [4:0] o5;
    logic [3:0] d4, s14, s24;
    o5 = 5'(op); d4 = 4'(rd); s14 = 4'(rs1); s24 = 4'(rs2);
    return {o5, i, d4, s14, s24, 14'd0};
  endfunction

  // Control bus from the instruction-set rules, bit positions listed by name
  function automatic logic [21:0] ref_ctrl(input logic [31:0] ir);
    int op;
    logic [21:0] c;
    // ALU opcodes 0..12 -> bit of their ALU signal (add=12 sub=11 cmp=10 mul=9 div=8 mod=7 lsl=6 lsr=5 asr=4 or=3 and=2 not=1 mov=0)
    int alu_bit [13] = '{12, 11, 9, 8, 7, 10, 2, 3, 1, 0, 6, 5, 4};
    op = int'(ir[31:27]);
    c = '0;
    if (op <= 12) begin
      c[alu_bit[op]] = 1'b1;
      c[16] = ir[26];
      if (op != 5) c[15] = 1'b1;
    end else if (op == 14) begin
      c[20] = 1'b1; c[16] = 1'b1; c[15] = 1'b1; c[12] = 1'b1;
    end else if (op == 15) begin
      c[21] = 1'b1; c[16] = 1'b1; c[12] = 1'b1;
    end else if (op == 16) c[19] = 1'b1;
    else if (op == 17) c[18] = 1'b1;
    else if (op == 18) c[14] = 1'b1;
    else if (op == 19) begin
      c[14] = 1'b1; c[13] = 1'b1; c[15] = 1'b1;
    end else if (op == 20) begin
      c[14] = 1'b1; c[17] = 1'b1;
    end
    return c;
  endfunction

  // ALU result from arithmetic on 64-bit signed values, truncated to 32 bits
  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, r;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b & 32'h1f);
    r = 0;
    case (op)
      0, 14, 15: r = sa + sb;
      1:  r = sa - sb;
      2:  r = sa * sb;
      3:  r = (sb == 0) ? 0 : sa / sb;
      4:  r = (sb == 0) ? 0 : sa % sb;
      6:  r = longint'(a & b);
      7:  r = longint'(a | b);
      8:  r = longint'(~b);
      9:  r = longint'(b);
      10: r = longint'(a) << sh;
      11: r = longint'({32'd0, a} >> sh);
      12: r = sa >>> sh;
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  // Present one instruction in EX (and a word in OF), check branch outputs, clock, check the latch
  task automatic run_ex(input string tag, input logic [31:0] ir, input logic [31:0] pc,
                        input logic [31:0] tgt, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] op2, input logic [3:0] fsel, input logic [31:0] ofi);
    int op;
    logic [21:0] c;
    logic [31:0] fa, f2b, f2, fb, exp_pc, exp_alu;
    bit exp_taken;
    op = int'(ir[31:27]);
    c = ref_ctrl(ir);
    ex_ir = ir; ex_ctrl = c; ex_pc = pc; ex_branch_target = tgt;
    ex_op_a = a; ex_op_b = b; ex_op2 = op2;
    {ma_ex_src1, rw_ex_src1, ma_ex_src2, rw_ex_src2} = fsel;
    of_ir = ofi;
    #1;
    fa  = fsel[3] ? fwd_ma_alu : (fsel[2] ? fwd_rw_data : a);
    f2b = fsel[1] ? fwd_ma_alu : (fsel[0] ? fwd_rw_data : b);
    f2  = fsel[1] ? fwd_ma_alu : (fsel[0] ? fwd_rw_data : op2);
    fb  = c[16] ? b : f2b;
    exp_taken = (op == 18) || (op == 19) || (op == 20) || (op == 16 && e_m) || (op == 17 && gt_m);
    exp_pc = (op == 20) ? fa : tgt;
    exp_alu = ref_alu(op, fa, fb);
    chk({tag, ".of_ctrl"}, 32'(of_ctrl), 32'(ref_ctrl(ofi)));
    chk({tag, ".taken"}, 32'(branch_taken), 32'(exp_taken));
    chk({tag, ".bpc"}, branch_pc, exp_pc);
    tick();
    chk({tag, ".alu"}, ma_alu_result, exp_alu);
    chk({tag, ".op2"}, ma_op2, f2);
    chk({tag, ".pc"}, ma_pc, pc);
    chk({tag, ".ir"}, ma_ir, ir);
    chk({tag, ".ctrl"}, 32'(ma_ctrl), 32'(c));
    if (op == 5) begin
      e_m  = (fa == fb);
      gt_m = ($signed(fa) > $signed(fb));
    end
  endtask

  initial begin
    int op;
    logic [31:0] ir, a, b;
    bit ib;
    logic [31:0] nop_ir;
    nop_ir = mk_ir(13, 0, 0, 0, 0);

    // reset phase: drive a ret in EX and an add in OF, everything must stay quiet
    reset = 1'b0;
    of_ir = 32'h0444_0005;
    ex_ir = mk_ir(20, 0, 0, 0, 0); ex_ctrl = ref_ctrl(ex_ir);
    ex_pc = 32'h10; ex_branch_target = 32'h20; ex_op_a = 32'h30; ex_op_b = 32'h1; ex_op2 = 32'h2;
    fwd_rw_data = 32'd9; fwd_ma_alu = 32'd7;
    {ma_ex_src1, rw_ex_src1, ma_ex_src2, rw_ex_src2} = 4'b0000;
    #1;
    chk("rst.of_ctrl", 32'(of_ctrl), 32'd0);
    chk("rst.taken", 32'(branch_taken), 32'd0);
    chk("rst.bpc", branch_pc, 32'd0);
    tick(); tick();
    chk("rst.ma_ir", ma_ir, 32'h6800_0000);
    chk("rst.ma_pc", ma_pc, 32'd0);
    chk("rst.ma_alu", ma_alu_result, 32'd0);
    chk("rst.ma_op2", ma_op2, 32'd0);
    chk("rst.ma_ctrl", 32'(ma_ctrl), 32'd0);
    reset = 1'b1;

    // decoder vectors
    of_ir = 32'h0444_0005;
    #1 chk("dec.add_imm", 32'(of_ctrl), 32'h0001_9000);
    of_ir = 32'h0C44_0005;
    #1 chk("dec.0c44", 32'(of_ctrl), 32'(ref_ctrl(32'h0C44_0005)));
    of_ir = mk_ir(23, 1, 3, 3, 3);
    #1 chk("dec.op23", 32'(of_ctrl), 32'd0);

    // ALU directed
    run_ex("sub", mk_ir(1, 0, 1, 2, 3), 32'h100, 0, 32'd3, 32'd10, 0, 4'b0000, mk_ir(14, 1, 1, 2, 0));
    chk("sub.const", ma_alu_result, 32'hFFFF_FFF9);
    run_ex("div", mk_ir(3, 0, 1, 2, 3), 32'h104, 0, -32'sd7, 32'd2, 0, 4'b0000, nop_ir);
    chk("div.const", ma_alu_result, -32'sd3);
    run_ex("mod", mk_ir(4, 0, 1, 2, 3), 32'h108, 0, -32'sd7, 32'd2, 0, 4'b0000, nop_ir);
    chk("mod.const", ma_alu_result, -32'sd1);
    run_ex("div0", mk_ir(3, 1, 1, 2, 0), 32'h10c, 0, 32'd77, 32'd0, 0, 4'b0000, nop_ir);
    chk("div0.const", ma_alu_result, 32'd0);
    run_ex("asr", mk_ir(12, 1, 1, 2, 0), 32'h110, 0, 32'h8000_0000, 32'd4, 0, 4'b0000, nop_ir);
    chk("asr.const", ma_alu_result, 32'hF800_0000);

    // forwarding: MA over RW on src1, RW on src2 for a store
    run_ex("fwd_add", mk_ir(0, 1, 1, 2, 0), 32'h114, 0, 32'd100, 32'd1, 0, 4'b1100, nop_ir);
    chk("fwd_add.const", ma_alu_result, 32'd8);
    run_ex("fwd_st", mk_ir(15, 1, 1, 2, 0), 32'h118, 0, 32'd40, 32'd4, 32'h55, 4'b0001, nop_ir);
    chk("fwd_st.const", ma_op2, 32'd9);

    // cmp then conditional branches on the registered flags
    run_ex("cmp55", mk_ir(5, 0, 0, 1, 2), 32'h11c, 0, 32'd5, 32'd5, 0, 4'b0000, nop_ir);
    run_ex("beq", mk_ir(16, 0, 0, 0, 0), 32'h120, 32'h40, 0, 0, 0, 4'b0000, nop_ir);
    run_ex("bgt", mk_ir(17, 0, 0, 0, 0), 32'h124, 32'h80, 0, 0, 0, 4'b0000, nop_ir);
    run_ex("ret", mk_ir(20, 0, 0, 15, 0), 32'h128, 32'h44, 32'h100, 0, 0, 4'b0000, nop_ir);

    // randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      op = int'($urandom_range(0, 23));
      ib = 1'($urandom_range(0, 1));
      ir = mk_ir(op, ib, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      ir[13:0] = 14'($urandom);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if ((op == 3 || op == 4) && $urandom_range(0, 3) == 0) b = 0;
      if (op == 5 && $urandom_range(0, 2) == 0) b = a;
      fwd_rw_data = $urandom;
      fwd_ma_alu = $urandom;
      run_ex("rnd", ir, $urandom, $urandom, a, b, $urandom, 4'($urandom_range(0, 15)), $urandom);
    end

    // mid-operation reset clears flags and latch
    fwd_rw_data = 32'd9; fwd_ma_alu = 32'd7;
    run_ex("cmp_pre", mk_ir(5, 0, 0, 1, 2), 32'h200, 0, 32'd5, 32'd5, 0, 4'b0000, nop_ir);
    run_ex("beq_pre", mk_ir(16, 0, 0, 0, 0), 32'h204, 32'h40, 0, 0, 0, 4'b0000, nop_ir);
    ex_ir = mk_ir(20, 0, 0, 0, 0); ex_ctrl = ref_ctrl(ex_ir); ex_op_a = 32'h300;
    of_ir = mk_ir(9, 1, 1, 0, 0);
    reset = 1'b0;
    #1;
    chk("mrst.of_ctrl", 32'(of_ctrl), 32'd0);
    chk("mrst.taken", 32'(branch_taken), 32'd0);
    chk("mrst.bpc", branch_pc, 32'd0);
    tick();
    chk("mrst.ma_ir", ma_ir, 32'h6800_0000);
    chk("mrst.ma_alu", ma_alu_result, 32'd0);
    chk("mrst.ma_ctrl", 32'(ma_ctrl), 32'd0);
    e_m = 1'b0; gt_m = 1'b0;
    reset = 1'b1;
    run_ex("beq_post", mk_ir(16, 0, 0, 0, 0), 32'h208, 32'h40, 0, 0, 0, 4'b0000, nop_ir);
    run_ex("bgt_post", mk_ir(17, 0, 0, 0, 0), 32'h20c, 32'h40, 0, 0, 0, 4'b0000, nop_ir);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
